apb_master_ctrl: RTL and testbench
==================================

// Module: apb_master_ctrl
// PURPOSE
//  APB3 initiator (bus master) for fabric logic. Accepts one read/write command at a
//  time on a valid/ready port and runs a full APB3 SETUP/ACCESS transfer to any APB
//  slave register block. Returns read data, PSLVERR status and a timeout flag on a
//  one-cycle response strobe. Sits opposite our APB slave wrappers, e.g. for
//  fabric-side self-test of peripheral registers without the MSS.
// PARAMETERS
//  ADDR_W   9    PADDR / cmd_addr width
//  DATA_W   32   PWDATA / PRDATA / data width
//  TIMEOUT  255  ACCESS cycles with PREADY=0 before abort; 0 = timeout disabled
// PORTS
//  PCLK         in   1       clock, rising edge
//  PRESET       in   1       asynchronous reset, active-high
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       one-cycle response strobe
//  rsp_rdata    out  DATA_W  read data (0 after a write or timeout)
//  rsp_err      out  1       PSLVERR seen, or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  busy         out  1       state != IDLE
//  PSEL, PENABLE, PWRITE  out  1  APB control
//  PADDR        out  ADDR_W  APB address
//  PWDATA       out  DATA_W  APB write data
//  PRDATA       in   DATA_W  APB read data
//  PREADY       in   1       slave ready
//  PSLVERR      in   1       slave error, valid only when PREADY=1 in ACCESS
// BEHAVIOUR
//  - PRESET=1 (async): state IDLE. All outputs 0 (PSEL, PENABLE, PWRITE, PADDR,
//    PWDATA, rsp_*, busy), timeout counter 0. cmd_ready=1 once PRESET is released.
//  - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB outputs registered.
//  - IDLE: cmd_ready=1 (decoded from state). On cmd_valid: latch write/addr/wdata
//    into PWRITE/PADDR/PWDATA, go to SETUP. PADDR/PWRITE/PWDATA hold their last
//    values in IDLE.
//  - SETUP (1 cycle): PSEL=1, PENABLE=0. Next state ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
//      PREADY=1: rsp_rdata <= PWRITE ? 0 : PRDATA; rsp_err <= PSLVERR;
//        rsp_timeout <= 0; PSEL/PENABLE <= 0; go to RESP.
//      PREADY=0: counter++. If TIMEOUT!=0 and counter reaches TIMEOUT
//        (TIMEOUT wait cycles): abort, PSEL/PENABLE <= 0, rsp_rdata <= 0,
//        rsp_err <= 1, rsp_timeout <= 1, go to RESP.
//  - Counter width is clog2(TIMEOUT+1). It clears on entry to SETUP and never wraps.
//  - RESP (1 cycle): rsp_valid=1, then IDLE. rsp_rdata/err/timeout hold until the
//    next response is loaded.
//  - Latency, zero wait states: accept at edge 0; SETUP in cycle 1; ACCESS in
//    cycle 2; rsp_valid in cycle 3; cmd_ready=1 again in cycle 4. N wait states
//    add N cycles. Minimum 4 cycles per command.
//  - No command queueing. cmd_valid outside IDLE is ignored and not latched.
//  - PREADY/PSLVERR are ignored outside ACCESS.
//  - Reset during a transfer: PSEL/PENABLE drop immediately, no rsp_valid is
//    issued, and the command is lost.
// TESTING
//  1 Write, PREADY=1: addr 0x100, wdata 0xA5 -> PSEL=1 cycle 1, PENABLE=1 cycle 2
//    with PADDR=0x100, PWDATA=0xA5; rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
//  2 Read, 3 wait states, PRDATA=0x0000_0003 -> PENABLE high 4 cycles,
//    rsp_valid cycle 6, rsp_rdata=3.
//  3 Read, PREADY=1 with PSLVERR=1 -> rsp_err=1, rsp_timeout=0; next command runs
//    normally.
//  4 TIMEOUT=8, PREADY stuck 0 -> after 8 ACCESS wait cycles PSEL=0, rsp_valid=1,
//    rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  5 PRESET pulse mid-ACCESS -> PSEL=PENABLE=0 same cycle, no rsp_valid; new write
//    after release completes as in test 1.
//  6 cmd_valid held with 2 commands back-to-back -> second accepted in cycle 4,
//    its SETUP in cycle 5; APB signals stable throughout each ACCESS.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//   APB3 initiator for fabric logic. Takes one read/write command at a time on a
//   valid/ready port, runs a full APB3 SETUP/ACCESS transfer and returns read
//   data, slave-error and timeout status on a one-cycle response strobe.
//
// Ports
//   PCLK, PRESET          clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake, accepted when both are high
//   cmd_write/addr/wdata  command contents (wdata ignored for reads)
//   rsp_valid             one-cycle response strobe
//   rsp_rdata             read data (0 after a write or a timeout)
//   rsp_err               PSLVERR seen, or timeout
//   rsp_timeout           transfer aborted because PREADY stayed low
//   busy                  controller is not idle
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR              APB completer inputs (used in ACCESS only)
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A disabled timeout still needs a legal 1-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               tmo_hit;

  // Wait-cycle count after this ACCESS cycle; saturates instead of wrapping.
  always_comb begin
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
      tmo_hit = 1'b1;
    end else begin
      tmo_hit = 1'b0;
    end
  end

  // Handshake/status decoded from state; ready is withheld while in reset.
  assign cmd_ready = (state_q == S_IDLE) && !PRESET;
  assign busy      = (state_q != S_IDLE);

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= {ADDR_W{1'b0}};
      PWDATA      <= {DATA_W{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {DATA_W{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            cnt_q   <= {CNT_W{1'b0}};
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY wins over the timeout on the last allowed cycle.
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? {DATA_W{1'b0}} : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (tmo_hit) begin
              rsp_rdata   <= {DATA_W{1'b0}};
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Self-checking bench for apb_master_ctrl (TIMEOUT=8). A table of directed
//   transfers is applied in a loop with the bench acting as APB completer, plus
//   hand-written sequences for reset, mid-transfer reset and back-to-back
//   commands.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            nwait;    // ACCESS cycles with PREADY=0 before PREADY=1
    logic [DW-1:0] prdata;
    logic          slverr;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    logic          e_tmo;
    int            e_acc;    // expected number of cycles with PENABLE=1
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer with the bench as completer; cycle 0 = accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    logic rdy;
    logic unstable;
    string tag;
    tag       = $sformatf("v%0d", idx);
    acc       = 0;
    unstable  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PREADY    = 1'b1;  // ignored outside ACCESS
    chk({tag, "_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
    tick;
    // Cycle 1: SETUP. Scramble command inputs to prove they are not re-latched.
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    cmd_write = ~v.wr;
    chk({tag, "_setup_psel"},   {31'd0, PSEL},      32'd1);
    chk({tag, "_setup_pen"},    {31'd0, PENABLE},   32'd0);
    chk({tag, "_setup_ready"},  {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_setup_paddr"},  {23'd0, PADDR},     {23'd0, v.addr});
    chk({tag, "_setup_pwdata"}, PWDATA,             v.wdata);
    chk({tag, "_setup_pwrite"}, {31'd0, PWRITE},    {31'd0, v.wr});
    tick;
    // ACCESS cycles; bounded so a stuck DUT still reaches the summary.
    for (int k = 0; k < 20; k++) begin
      if (PENABLE !== 1'b1) break;
      acc++;
      if (PSEL !== 1'b1 || PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.wr)
        unstable = 1'b1;
      rdy     = (k >= v.nwait);
      PREADY  = rdy;
      PRDATA  = rdy ? v.prdata : ~v.prdata;
      PSLVERR = rdy ? v.slverr : ~v.slverr;
      tick;
    end
    PREADY  = 1'b1;
    PRDATA  = 32'hFFFF_FFFF;
    PSLVERR = 1'b1;
    chk({tag, "_access_cycles"}, acc,                  v.e_acc);
    chk({tag, "_access_stable"}, {31'd0, unstable},    32'd0);
    chk({tag, "_rsp_valid"},     {31'd0, rsp_valid},   32'd1);
    chk({tag, "_rsp_rdata"},     rsp_rdata,            v.e_rdata);
    chk({tag, "_rsp_err"},       {31'd0, rsp_err},     {31'd0, v.e_err});
    chk({tag, "_rsp_tmo"},       {31'd0, rsp_timeout}, {31'd0, v.e_tmo});
    chk({tag, "_resp_psel"},     {31'd0, PSEL},        32'd0);
    chk({tag, "_resp_busy"},     {31'd0, busy},        32'd1);
    tick;
    chk({tag, "_idle_rspv"},  {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_idle_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_hold_rdata"}, rsp_rdata,          v.e_rdata);
    chk({tag, "_hold_paddr"}, {23'd0, PADDR},     {23'd0, v.addr});
  endtask

  initial begin
    int seen;
    // wr, addr, wdata, nwait, prdata, slverr, e_rdata, e_err, e_tmo, e_acc
    vecs[0] = '{1'b1, 9'h100, 32'h0000_00A5, 0,   32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 9'h004, 32'h0000_0000, 3,   32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 9'h008, 32'h0000_0000, 0,   32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 9'h00C, 32'h0000_0000, 0,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[4] = '{1'b0, 9'h1FF, 32'h0000_0000, 100, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8};
    vecs[5] = '{1'b1, 9'h055, 32'hCAFE_F00D, 7,   32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 8};

    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 9'h000;
    cmd_wdata = 32'h0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state.
    tick;
    tick;
    chk("rst_psel",   {31'd0, PSEL},      32'd0);
    chk("rst_pen",    {31'd0, PENABLE},   32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd0);
    chk("rst_paddr",  {23'd0, PADDR},     32'd0);
    chk("rst_pwdata", PWDATA,             32'd0);
    PRESET = 1'b0;
    #1;
    chk("rel_ready",  {31'd0, cmd_ready}, 32'd1);
    tick;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset mid-ACCESS: bus drops at once, no response, command lost.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h0AA;
    PREADY    = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("mid_access_pen", {31'd0, PENABLE}, 32'd1);
    tick;
    PRESET = 1'b1;
    #1;
    chk("mid_rst_psel", {31'd0, PSEL},    32'd0);
    chk("mid_rst_pen",  {31'd0, PENABLE}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy},    32'd0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (rsp_valid === 1'b1) seen++;
    end
    PRESET = 1'b0;
    PREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    chk("mid_rst_no_rsp", seen, 0);
    run_vec(vecs[0], 10);

    // Back-to-back: cmd_valid held; second command waits for IDLE.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h021;
    cmd_wdata = 32'h0000_0A0A;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    tick;  // edge 0: A accepted
    cmd_write = 1'b0;
    cmd_addr  = 9'h042;
    cmd_wdata = 32'h0000_0B0B;
    PRDATA    = 32'h0000_BEEF;
    seen = 0;
    for (int c = 1; c <= 3; c++) begin
      if (PADDR !== 9'h021 || PWDATA !== 32'h0000_0A0A || PWRITE !== 1'b1 || cmd_ready !== 1'b0)
        seen++;
      if (c == 3) chk("b2b_a_rspv", {31'd0, rsp_valid}, 32'd1);
      tick;
    end
    chk("b2b_a_stable",  seen, 0);
    chk("b2b_c4_ready",  {31'd0, cmd_ready}, 32'd1);
    tick;  // edge 4: B accepted
    cmd_valid = 1'b0;
    chk("b2b_c5_psel",  {31'd0, PSEL},    32'd1);
    chk("b2b_c5_pen",   {31'd0, PENABLE}, 32'd0);
    chk("b2b_c5_paddr", {23'd0, PADDR},   32'h042);
    tick;
    chk("b2b_c6_pen",   {31'd0, PENABLE}, 32'd1);
    tick;
    chk("b2b_c7_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c7_rdata", rsp_rdata,          32'h0000_BEEF);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
